// File: rtl/fdivr4_engine.sv
// fdivr4_engine: iterative radix-4 SRT divider of 1.x by 1.d with a carry-save residual,
// table-based digit selection and on-the-fly quotient conversion.
module fdivr4_engine #(
    parameter int N         = 24,
    parameter int COPIES    = 1,
    parameter int EARLYTERM = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [N-1:0]               x,
    input  logic [N-1:0]               d,
    output logic                       busy,
    output logic                       done,
    output logic [2*((N+4)/2)-1:0]     quot,
    output logic                       sticky
);
    localparam int K  = (N + 4) / 2;
    localparam int QW = 2 * K;
    localparam int RW = N + 6;
    localparam int CW = $clog2(K + COPIES + 1);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
    localparam logic signed [6:0] T2 [0:7] = '{7'sd12, 7'sd14, 7'sd16, 7'sd16, 7'sd18, 7'sd20, 7'sd20, 7'sd24};
    localparam logic signed [6:0] T1 [0:7] = '{7'sd4, 7'sd4, 7'sd4, 7'sd4, 7'sd6, 7'sd6, 7'sd8, 7'sd8};
    localparam logic signed [6:0] T0 [0:7] = '{-7'sd4, -7'sd4, -7'sd6, -7'sd6, -7'sd6, -7'sd8, -7'sd8, -7'sd8};
    localparam logic signed [6:0] TM [0:7] = '{-7'sd13, -7'sd14, -7'sd16, -7'sd17, -7'sd18, -7'sd20, -7'sd22, -7'sd22};
    localparam logic [RW+3:0] LIM4 = {4'b0001, {RW{1'b0}}};

    logic [1:0]    state;
    logic [RW-1:0] ws, wc, dv, dv2, ws_n, wc_n, wf;
    logic [N-1:0]  dq;
    logic [2:0]    a;
    logic [QW-1:0] u, um, u_n, um_n;
    logic [CW-1:0] cnt, ncnt, left;
    logic [CW:0]   sh;
    logic          fin;
    logic [RW-1:0] ws_c [0:COPIES];
    logic [RW-1:0] wc_c [0:COPIES];
    logic [QW-1:0] u_c  [0:COPIES];
    logic [QW-1:0] um_c [0:COPIES];

    assign dv  = {4'b0001, dq, 2'b00};
    assign dv2 = {dv[RW-2:0], 1'b0};
    assign a   = dq[N-1:N-3];
    assign ws_c[0] = ws;
    assign wc_c[0] = wc;
    assign u_c[0]  = u;
    assign um_c[0] = um;

    // Steps past digit K in the final cycle pass the state through unchanged.
    for (genvar i = 0; i < COPIES; i++) begin : g_step
        logic [RW-1:0]   s4, c4, w4, add, maj, ns, nc, wn;
        logic [RW+3:0]   a4, an;
        logic signed [6:0] wm;
        logic            p2, p1, m1, m2, vld, ok;
        assign vld = int'(cnt) + i < K;
        assign s4  = {ws_c[i][RW-3:0], 2'b00};
        assign c4  = {wc_c[i][RW-3:0], 2'b00};
        assign w4  = s4 + c4;
        assign wm  = w4[RW-1:RW-7];
        assign p2  = wm >= T2[a];
        assign p1  = wm >= T1[a] && !p2;
        assign m1  = wm < T0[a] && wm >= TM[a];
        assign m2  = wm < TM[a];
        assign add = p2 ? ~dv2 : p1 ? ~dv : m1 ? dv : m2 ? dv2 : '0;
        assign maj = (s4 & c4) | (s4 & add) | (c4 & add);
        assign ns  = s4 ^ c4 ^ add;
        assign nc  = {maj[RW-2:0], p2 | p1};
        assign wn  = ns + nc;
        assign ws_c[i+1] = vld ? ns : ws_c[i];
        assign wc_c[i+1] = vld ? nc : wc_c[i];
        assign u_c[i+1]  = !vld ? u_c[i] : p2 ? {u_c[i][QW-3:0], 2'b10} : p1 ? {u_c[i][QW-3:0], 2'b01} :
                           m1 ? {um_c[i][QW-3:0], 2'b11} : m2 ? {um_c[i][QW-3:0], 2'b10} : {u_c[i][QW-3:0], 2'b00};
        assign um_c[i+1] = !vld ? um_c[i] : p2 ? {u_c[i][QW-3:0], 2'b01} : p1 ? {u_c[i][QW-3:0], 2'b00} :
                           m1 ? {um_c[i][QW-3:0], 2'b10} : m2 ? {um_c[i][QW-3:0], 2'b01} : {um_c[i][QW-3:0], 2'b11};
        assign a4 = w4[RW-1] ? -{{4{w4[RW-1]}}, w4} : {4'b0000, w4};
        assign an = wn[RW-1] ? -{{4{wn[RW-1]}}, wn} : {4'b0000, wn};
        assign ok = a4 + {a4[RW+2:0], 1'b0} <= LIM4 && an + {an[RW+2:0], 1'b0} <= {4'b0000, dv2};
        assert property (@(posedge clk) disable iff (reset) (state == BUSY && vld) |-> ok);
    end

    assign ws_n = ws_c[COPIES];
    assign wc_n = wc_c[COPIES];
    assign u_n  = u_c[COPIES];
    assign um_n = um_c[COPIES];
    assign wf   = ws_n + wc_n;
    assign ncnt = cnt + CW'(COPIES);
    assign fin  = ncnt >= CW'(K) || (EARLYTERM != 0 && wf == '0);
    assign left = ncnt >= CW'(K) ? '0 : CW'(K) - ncnt;
    assign sh   = {left, 1'b0};
    assign busy = state == BUSY;
    assign done = state == DONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ws     <= '0;
            wc     <= '0;
            dq     <= '0;
            u      <= '0;
            um     <= '0;
            cnt    <= '0;
            quot   <= '0;
            sticky <= '0;
        end else if (state == BUSY) begin
            ws  <= ws_n;
            wc  <= wc_n;
            u   <= u_n;
            um  <= um_n;
            cnt <= ncnt;
            if (fin) begin
                state  <= DONE;
                quot   <= wf[RW-1] ? um_n << sh : u_n << sh;
                sticky <= wf[RW-1] ? (wf + dv) != '0 : wf != '0;
            end
        end else if (start) begin
            state <= BUSY;
            ws    <= {2'b00, 4'b0001, x};
            wc    <= '0;
            dq    <= d;
            u     <= '0;
            um    <= '0;
            cnt   <= '0;
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_fdivr4_engine.sv
// tb_fdivr4_engine: four divider configurations checked against an integer division model
// through per-instance scoreboards, plus cycle-exact checks on the N=24 non-early instance.
module tb_fdivr4_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  st = '0;
    logic [63:0] xin = '0, din = '0;
    logic [3:0]  busy, done, sticky;
    logic [27:0] q0, q1;
    logic [13:0] q2;
    logic [55:0] q3;
    int          errors = 0, checks = 0;
    logic [128:0] sb0[$], sb1[$], sb2[$], sb3[$];

    always #5 clk = ~clk;

    fdivr4_engine #(.N(24), .COPIES(1), .EARLYTERM(0)) u0 (.clk(clk), .reset(reset), .start(st[0]), .x(xin[23:0]),
        .d(din[23:0]), .busy(busy[0]), .done(done[0]), .quot(q0), .sticky(sticky[0]));
    fdivr4_engine #(.N(24), .COPIES(1), .EARLYTERM(1)) u1 (.clk(clk), .reset(reset), .start(st[1]), .x(xin[23:0]),
        .d(din[23:0]), .busy(busy[1]), .done(done[1]), .quot(q1), .sticky(sticky[1]));
    fdivr4_engine #(.N(11), .COPIES(2), .EARLYTERM(1)) u2 (.clk(clk), .reset(reset), .start(st[2]), .x(xin[10:0]),
        .d(din[10:0]), .busy(busy[2]), .done(done[2]), .quot(q2), .sticky(sticky[2]));
    fdivr4_engine #(.N(53), .COPIES(4), .EARLYTERM(0)) u3 (.clk(clk), .reset(reset), .start(st[3]), .x(xin[52:0]),
        .d(din[52:0]), .busy(busy[3]), .done(done[3]), .quot(q3), .sticky(sticky[3]));

    // {sticky, quotient} from exact integer division of the scaled significands
    function automatic logic [128:0] model(input int n, input logic [63:0] x, input logic [63:0] d);
        int k = (n + 4) / 2;
        logic [127:0] msk, num, den;
        msk = (128'd1 << n) - 128'd1;
        num = ((128'd1 << n) + ({64'd0, x} & msk)) << (2 * (k - 1));
        den = (128'd1 << n) + ({64'd0, d} & msk);
        return {(num % den) != 128'd0, num / den};
    endfunction

    always @(negedge clk) if (!reset && done[0]) begin : mon0
        logic [128:0] e;
        checks++;
        if (sb0.size() == 0) begin errors++; $display("FAIL u0 unexpected done quot=%h", q0); end
        else begin
            e = sb0.pop_front();
            if ({sticky[0], q0} !== {e[128], e[27:0]}) begin
                errors++; $display("FAIL u0 result got=%h/%b required=%h/%b", q0, sticky[0], e[27:0], e[128]);
            end
        end
    end
    always @(negedge clk) if (!reset && done[1]) begin : mon1
        logic [128:0] e;
        checks++;
        if (sb1.size() == 0) begin errors++; $display("FAIL u1 unexpected done quot=%h", q1); end
        else begin
            e = sb1.pop_front();
            if ({sticky[1], q1} !== {e[128], e[27:0]}) begin
                errors++; $display("FAIL u1 result got=%h/%b required=%h/%b", q1, sticky[1], e[27:0], e[128]);
            end
        end
    end
    always @(negedge clk) if (!reset && done[2]) begin : mon2
        logic [128:0] e;
        checks++;
        if (sb2.size() == 0) begin errors++; $display("FAIL u2 unexpected done quot=%h", q2); end
        else begin
            e = sb2.pop_front();
            if ({sticky[2], q2} !== {e[128], e[13:0]}) begin
                errors++; $display("FAIL u2 result got=%h/%b required=%h/%b", q2, sticky[2], e[13:0], e[128]);
            end
        end
    end
    always @(negedge clk) if (!reset && done[3]) begin : mon3
        logic [128:0] e;
        checks++;
        if (sb3.size() == 0) begin errors++; $display("FAIL u3 unexpected done quot=%h", q3); end
        else begin
            e = sb3.pop_front();
            if ({sticky[3], q3} !== {e[128], e[55:0]}) begin
                errors++; $display("FAIL u3 result got=%h/%b required=%h/%b", q3, sticky[3], e[55:0], e[128]);
            end
        end
    end

    task automatic go(input logic [3:0] m, input logic [63:0] a, input logic [63:0] b);
        xin = a;
        din = b;
        if (m[0]) sb0.push_back(model(24, a, b));
        if (m[1]) sb1.push_back(model(24, a, b));
        if (m[2]) sb2.push_back(model(11, a, b));
        if (m[3]) sb3.push_back(model(53, a, b));
        st = m;
        @(posedge clk);
        #1 st = '0;
    endtask

    task automatic wait_done(input int i, output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!done[i] && cyc < 40);
        checks++;
        if (!done[i]) begin errors++; $display("FAIL wait_done u%0d timeout", i); end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy != 4'b0000 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (busy != 4'b0000) begin errors++; $display("FAIL idle timeout busy=%b required=0000", busy); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 4;
        if (busy !== 4'b0000) begin errors++; $display("FAIL reset busy=%b required=0000", busy); end
        if (done !== 4'b0000) begin errors++; $display("FAIL reset done=%b required=0000", done); end
        if (sticky !== 4'b0000) begin errors++; $display("FAIL reset sticky=%b required=0000", sticky); end
        if ({q0, q1, q2, q3} !== '0) begin errors++; $display("FAIL reset quot=%h/%h/%h/%h required=0", q0, q1, q2, q3); end
        reset = 1'b0;
    endtask

    task automatic test_exact();
        @(negedge clk);
        go(4'b0001, 64'd0, 64'd0);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            checks += 2;
            if (busy[0] !== (c <= 14)) begin errors++; $display("FAIL exact busy cycle %0d got=%b", c, busy[0]); end
            if (done[0] !== (c == 15)) begin errors++; $display("FAIL exact done cycle %0d got=%b", c, done[0]); end
            if (c == 15) begin
                checks += 2;
                if (q0 !== 28'h4000000) begin errors++; $display("FAIL exact quot=%h required=4000000", q0); end
                if (sticky[0] !== 1'b0) begin errors++; $display("FAIL exact sticky=%b required=0", sticky[0]); end
            end
        end
    endtask

    task automatic test_early();
        int cyc;
        @(negedge clk);
        go(4'b0010, 64'h800000, 64'd0);
        wait_done(1, cyc);
        checks += 3;
        if (cyc != 3) begin errors++; $display("FAIL early cycle=%0d required=3", cyc); end
        if (q1 !== 28'h6000000) begin errors++; $display("FAIL early quot=%h required=6000000", q1); end
        if (sticky[1] !== 1'b0) begin errors++; $display("FAIL early sticky=%b required=0", sticky[1]); end
        @(negedge clk);
        go(4'b0010, 64'd0, 64'd0);
        wait_done(1, cyc);
        checks += 2;
        if (cyc != 2) begin errors++; $display("FAIL early1 cycle=%0d required=2", cyc); end
        if (q1 !== 28'h4000000) begin errors++; $display("FAIL early1 quot=%h required=4000000", q1); end
    endtask

    task automatic test_recip();
        int cyc;
        @(negedge clk);
        go(4'b0001, 64'd0, 64'h800000);
        wait_done(0, cyc);
        checks += 2;
        if (q0 !== 28'h2AAAAAA) begin errors++; $display("FAIL recip quot=%h required=2AAAAAA", q0); end
        if (sticky[0] !== 1'b1) begin errors++; $display("FAIL recip sticky=%b required=1", sticky[0]); end
    endtask

    task automatic test_max();
        int cyc;
        logic [63:0] r;
        @(negedge clk);
        go(4'b0001, 64'hFFFFFF, 64'd0);
        wait_done(0, cyc);
        checks += 3;
        if (q0 !== 28'h7FFFFFC) begin errors++; $display("FAIL max quot=%h required=7FFFFFC", q0); end
        if (q0[27] !== 1'b0) begin errors++; $display("FAIL max range quot=%h required below 8000000", q0); end
        if (sticky[0] !== 1'b0) begin errors++; $display("FAIL max sticky=%b required=0", sticky[0]); end
        for (int i = 0; i < 8; i++) begin
            wait_idle();
            r = {$urandom, $urandom};
            r[23:21] = 3'(i);
            r[10:8]  = 3'(i);
            r[52:50] = 3'(i);
            go(4'b1111, {$urandom, $urandom}, r);
        end
        wait_idle();
    endtask

    task automatic test_abort();
        logic [128:0] e;
        bit seen = 0;
        @(negedge clk);
        go(4'b0001, 64'h3A5C11, 64'h71B0E2);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb0.delete();
        checks++;
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL abort busy=%b required=0", busy[0]); end
        for (int c = 0; c < 20; c++) begin @(negedge clk); seen |= done[0]; end
        checks++;
        if (seen) begin errors++; $display("FAIL abort done seen=1 required=0"); end
        e = model(24, 64'h5E01F7, 64'h0C4D29);
        go(4'b0001, 64'h5E01F7, 64'h0C4D29);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            checks++;
            if (done[0] !== (c == 15)) begin errors++; $display("FAIL abort2 done cycle %0d got=%b", c, done[0]); end
        end
        checks++;
        if (q0 !== e[27:0]) begin errors++; $display("FAIL abort2 quot=%h required=%h", q0, e[27:0]); end
    endtask

    task automatic test_back_to_back();
        logic [128:0] e1, e2;
        e1 = model(24, 64'h123456, 64'h654321);
        e2 = model(24, 64'h0F0F0F, 64'h333333);
        @(negedge clk);
        go(4'b0001, 64'h123456, 64'h654321);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 2) begin xin = 64'hABCDEF; din = 64'h1; st = 4'b0001; end
            if (c == 3) st = '0;
            checks++;
            if (done[0] !== (c == 15)) begin errors++; $display("FAIL ignore done cycle %0d got=%b", c, done[0]); end
        end
        checks++;
        if (q0 !== e1[27:0]) begin errors++; $display("FAIL ignore quot=%h required=%h", q0, e1[27:0]); end
        go(4'b0001, 64'h0F0F0F, 64'h333333);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            checks++;
            if (done[0] !== (c == 15)) begin errors++; $display("FAIL b2b done cycle %0d got=%b", c, done[0]); end
        end
        checks++;
        if (q0 !== e2[27:0]) begin errors++; $display("FAIL b2b quot=%h required=%h", q0, e2[27:0]); end
    endtask

    task automatic test_random();
        logic [63:0] a, b;
        for (int i = 0; i < 300; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 16 == 0) b = a;
            if (i % 16 == 1) a = '0;
            if (i % 16 == 2) b = '1;
            wait_idle();
            go(4'b1111, a, b);
        end
        wait_idle();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_exact();
        test_early();
        test_recip();
        test_max();
        test_abort();
        test_back_to_back();
        test_random();
        checks += 4;
        if (sb0.size() != 0) begin errors++; $display("FAIL u0 pending=%0d required=0", sb0.size()); end
        if (sb1.size() != 0) begin errors++; $display("FAIL u1 pending=%0d required=0", sb1.size()); end
        if (sb2.size() != 0) begin errors++; $display("FAIL u2 pending=%0d required=0", sb2.size()); end
        if (sb3.size() != 0) begin errors++; $display("FAIL u3 pending=%0d required=0", sb3.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
